// File: rtl/uart_pkg.sv
// Shared UART definitions: default frame geometry and the receive FSM state type.
package uart_pkg;
  localparam int OVERSAMPLE_DEF = 16;
  localparam int DATA_BITS_DEF  = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } uart_state_t;
endpackage

// File: rtl/baud_rate_gen.sv
// Divides the system clock into a one-cycle rxclk_en strobe every DIVISOR cycles.
module baud_rate_gen #(
  parameter int DIVISOR = 28
) (
  input  logic clk_50m,
  input  logic rst,
  output logic rxclk_en
);
  localparam int W = $clog2(DIVISOR);

  logic [W-1:0] r_cnt;
  logic         r_en;

  always_ff @(posedge clk_50m) begin
    if (rst) begin
      r_cnt <= '0;
      r_en  <= 1'b0;
    end else if (r_cnt == W'(DIVISOR - 1)) begin
      r_cnt <= '0;
      r_en  <= 1'b1;
    end else begin
      r_cnt <= r_cnt + W'(1);
      r_en  <= 1'b0;
    end
  end

  assign rxclk_en = r_en;
endmodule

// File: rtl/rx_sync.sv
// Two-flop synchronizer for the asynchronous serial line; resets to the idle-high level.
module rx_sync (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_async,
  output logic o_sync
);
  logic r_meta;
  logic r_sync;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_meta <= 1'b1;
      r_sync <= 1'b1;
    end else begin
      r_meta <= i_async;
      r_sync <= r_meta;
    end
  end

  assign o_sync = r_sync;
endmodule

// File: rtl/uart_receiver.sv
// Oversampling UART receiver: mid-bit sampling, LSB-first, ready/overrun/framing-error flags.
module uart_receiver
  import uart_pkg::*;
#(
  parameter int OVERSAMPLE = OVERSAMPLE_DEF,
  parameter int DATA_BITS  = DATA_BITS_DEF
) (
  input  logic                 clk_50m,
  input  logic                 rst,
  input  logic                 rxclk_en,
  input  logic                 rx,
  input  logic                 rdy_clr,
  output logic [DATA_BITS-1:0] data,
  output logic                 rdy,
  output logic                 frame_err,
  output logic                 overrun,
  output uart_state_t          dbg_state
);
  localparam int CNT_W = $clog2(OVERSAMPLE);
  localparam int IDX_W = $clog2(DATA_BITS);
  localparam logic [CNT_W-1:0] CNT_MID  = CNT_W'(OVERSAMPLE / 2 - 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(OVERSAMPLE - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DATA_BITS - 1);

  uart_state_t          r_state, w_state_nxt;
  logic [CNT_W-1:0]     r_cnt, w_cnt_nxt;
  logic [IDX_W-1:0]     r_idx, w_idx_nxt;
  logic [DATA_BITS-1:0] r_shift, w_shift_nxt;
  logic [DATA_BITS-1:0] r_data, w_data_nxt;
  logic                 r_rdy, w_rdy_nxt;
  logic                 r_ovr, w_ovr_nxt;
  logic                 r_ferr;
  logic                 w_rx;
  logic                 w_good;
  logic                 w_bad;

  rx_sync u_rx_sync (
    .i_clk   (clk_50m),
    .i_rst   (rst),
    .i_async (rx),
    .o_sync  (w_rx)
  );

  always_ff @(posedge clk_50m) begin
    if (rst) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_idx   <= '0;
      r_shift <= '0;
      r_data  <= '0;
      r_rdy   <= 1'b0;
      r_ovr   <= 1'b0;
      r_ferr  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_idx   <= w_idx_nxt;
      r_shift <= w_shift_nxt;
      r_data  <= w_data_nxt;
      r_rdy   <= w_rdy_nxt;
      r_ovr   <= w_ovr_nxt;
      r_ferr  <= w_bad;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_idx_nxt   = r_idx;
    w_shift_nxt = r_shift;
    w_good      = 1'b0;
    w_bad       = 1'b0;
    if (rxclk_en) begin
      case (r_state)
        IDLE: begin
          if (!w_rx) begin
            w_state_nxt = START;
            w_cnt_nxt   = '0;
          end
        end
        START: begin
          // A start bit that is high again at mid-bit was only a glitch.
          if (r_cnt == CNT_MID) begin
            if (!w_rx) begin
              w_state_nxt = DATA;
              w_cnt_nxt   = '0;
              w_idx_nxt   = '0;
            end else begin
              w_state_nxt = IDLE;
            end
          end else begin
            w_cnt_nxt = r_cnt + CNT_W'(1);
          end
        end
        DATA: begin
          if (r_cnt == CNT_LAST) begin
            w_shift_nxt = {w_rx, r_shift[DATA_BITS-1:1]};
            w_cnt_nxt   = '0;
            if (r_idx == IDX_LAST) begin
              w_state_nxt = STOP;
            end else begin
              w_idx_nxt = r_idx + IDX_W'(1);
            end
          end else begin
            w_cnt_nxt = r_cnt + CNT_W'(1);
          end
        end
        STOP: begin
          // Return to IDLE at mid stop bit so a back-to-back start edge is not missed.
          if (r_cnt == CNT_LAST) begin
            w_state_nxt = IDLE;
            w_good      = w_rx;
            w_bad       = !w_rx;
          end else begin
            w_cnt_nxt = r_cnt + CNT_W'(1);
          end
        end
        default: w_state_nxt = IDLE;
      endcase
    end
  end

  always_comb begin
    w_data_nxt = r_data;
    w_rdy_nxt  = r_rdy;
    w_ovr_nxt  = r_ovr;
    if (rdy_clr) begin
      w_rdy_nxt = 1'b0;
      w_ovr_nxt = 1'b0;
    end
    // A completing byte wins over a simultaneous acknowledge.
    if (w_good) begin
      w_data_nxt = r_shift;
      w_rdy_nxt  = 1'b1;
      w_ovr_nxt  = r_rdy && !rdy_clr;
    end
  end

  assign data      = r_data;
  assign rdy       = r_rdy;
  assign overrun   = r_ovr;
  assign frame_err = r_ferr;
  assign dbg_state = r_state;
endmodule

// File: tb/tb_uart_receiver.sv
// Self-checking bench for uart_receiver: directed vector table, hand sequences, random frames vs. model.
module tb_uart_receiver;
  import uart_pkg::*;

  logic        clk_50m = 1'b0;
  logic        rst     = 1'b1;
  logic        rx      = 1'b1;
  logic        rdy_clr = 1'b0;
  logic        rxclk_en;
  logic [7:0]  data;
  logic        rdy;
  logic        frame_err;
  logic        overrun;
  uart_state_t dbg_state;

  int n_cmp      = 0;
  int n_bad      = 0;
  int ferr_total = 0;

  always #10 clk_50m = ~clk_50m;

  baud_rate_gen #(.DIVISOR(28)) u_baud (
    .clk_50m  (clk_50m),
    .rst      (rst),
    .rxclk_en (rxclk_en)
  );

  uart_receiver #(.OVERSAMPLE(16), .DATA_BITS(8)) dut (
    .clk_50m   (clk_50m),
    .rst       (rst),
    .rxclk_en  (rxclk_en),
    .rx        (rx),
    .rdy_clr   (rdy_clr),
    .data      (data),
    .rdy       (rdy),
    .frame_err (frame_err),
    .overrun   (overrun),
    .dbg_state (dbg_state)
  );

  always @(negedge clk_50m) if (frame_err) ferr_total++;

  typedef struct {
    logic [7:0] byt;
    logic       stop;
    logic       clr_at_done;
    logic       clr_after;
    logic [7:0] exp_data;
    logic       exp_rdy;
    logic       exp_ovr;
    int         exp_ferr;
  } vec_t;

  vec_t vecs[8];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic wait_tick();
    int guard = 0;
    do begin
      @(negedge clk_50m);
      guard++;
    end while (!rxclk_en && guard < 100);
    if (!rxclk_en) begin
      n_cmp++;
      n_bad++;
      $display("FAIL tick_timeout: no rxclk_en within %0d cycles", guard);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $fatal(1, "rxclk_en stopped");
    end
  endtask

  task automatic send_bits(input logic b, input int n);
    rx = b;
    repeat (n) wait_tick();
  endtask

  // The receiver samples the stop bit on the 9th tick after it is driven.
  task automatic send_frame(input logic [7:0] byt, input logic stop, input logic clr_at_done);
    send_bits(1'b0, 16);
    for (int i = 0; i < 8; i++) send_bits(byt[i], 16);
    rx = stop;
    repeat (9) wait_tick();
    rdy_clr = clr_at_done;
    @(negedge clk_50m);
    rdy_clr = 1'b0;
    repeat (7) wait_tick();
    rx = 1'b1;
  endtask

  task automatic pulse_clr();
    rdy_clr = 1'b1;
    @(negedge clk_50m);
    rdy_clr = 1'b0;
  endtask

  initial begin
    logic [7:0] m_data;
    logic       m_rdy;
    logic       m_ovr;
    int         f0;

    vecs[0] = '{8'h3C, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1};
    vecs[1] = '{8'hA5, 1'b1, 1'b0, 1'b1, 8'hA5, 1'b1, 1'b0, 0};
    vecs[2] = '{8'h11, 1'b1, 1'b0, 1'b0, 8'h11, 1'b1, 1'b0, 0};
    vecs[3] = '{8'h22, 1'b1, 1'b0, 1'b1, 8'h22, 1'b1, 1'b1, 0};
    vecs[4] = '{8'h99, 1'b1, 1'b0, 1'b0, 8'h99, 1'b1, 1'b0, 0};
    vecs[5] = '{8'hC3, 1'b1, 1'b1, 1'b0, 8'hC3, 1'b1, 1'b0, 0};
    vecs[6] = '{8'h0F, 1'b0, 1'b0, 1'b0, 8'hC3, 1'b1, 1'b0, 1};
    vecs[7] = '{8'h44, 1'b1, 1'b0, 1'b1, 8'h44, 1'b1, 1'b1, 0};

    // Clock/reset
    rst = 1'b1;
    repeat (5) @(negedge clk_50m);
    check("reset_data", 32'(data), 32'h0);
    check("reset_rdy", 32'(rdy), 32'h0);
    check("reset_ovr", 32'(overrun), 32'h0);
    check("reset_ferr", 32'(frame_err), 32'h0);
    check("reset_state", 32'(dbg_state), 32'(IDLE));
    rst = 1'b0;
    send_bits(1'b1, 4);

    // Glitch: low for 3 ticks is accepted as a start edge, then rejected at mid-bit
    send_bits(1'b0, 3);
    check("glitch_in_start", 32'(dbg_state), 32'(START));
    send_bits(1'b1, 10);
    check("glitch_state", 32'(dbg_state), 32'(IDLE));
    check("glitch_rdy", 32'(rdy), 32'h0);
    check("glitch_data", 32'(data), 32'h0);

    // Directed vector table
    for (int i = 0; i < 8; i++) begin
      f0 = ferr_total;
      send_frame(vecs[i].byt, vecs[i].stop, vecs[i].clr_at_done);
      check($sformatf("vec%0d_data", i), 32'(data), 32'(vecs[i].exp_data));
      check($sformatf("vec%0d_rdy", i), 32'(rdy), 32'(vecs[i].exp_rdy));
      check($sformatf("vec%0d_ovr", i), 32'(overrun), 32'(vecs[i].exp_ovr));
      check($sformatf("vec%0d_ferr_cycles", i), 32'(ferr_total - f0), 32'(vecs[i].exp_ferr));
      if (vecs[i].clr_after) begin
        pulse_clr();
        check($sformatf("vec%0d_clr_rdy", i), 32'(rdy), 32'h0);
        check($sformatf("vec%0d_clr_ovr", i), 32'(overrun), 32'h0);
        check($sformatf("vec%0d_clr_data", i), 32'(data), 32'(vecs[i].exp_data));
      end
      send_bits(1'b1, 2);
    end

    // Reset in the middle of bit 4 of 0x77
    send_bits(1'b0, 16);
    for (int i = 0; i < 4; i++) send_bits(1'b1 & (8'h77 >> i), 16);
    send_bits(1'b1, 5);
    rst = 1'b1;
    @(negedge clk_50m);
    check("midrst_data", 32'(data), 32'h0);
    check("midrst_rdy", 32'(rdy), 32'h0);
    check("midrst_ovr", 32'(overrun), 32'h0);
    check("midrst_ferr", 32'(frame_err), 32'h0);
    check("midrst_state", 32'(dbg_state), 32'(IDLE));
    rst = 1'b0;
    send_bits(1'b1, 3);
    f0 = ferr_total;
    send_frame(8'h5A, 1'b1, 1'b0);
    check("post_rst_data", 32'(data), 32'h5A);
    check("post_rst_rdy", 32'(rdy), 32'h1);
    check("post_rst_ovr", 32'(overrun), 32'h0);
    check("post_rst_ferr", 32'(ferr_total - f0), 32'h0);

    // Random frames against a frame-level model
    m_data = 8'h5A;
    m_rdy  = 1'b1;
    m_ovr  = 1'b0;
    for (int n = 0; n < 6; n++) begin
      logic [7:0] byt;
      logic       stop;
      logic       clr_done;
      int         exp_ferr;
      byt      = 8'($urandom_range(0, 255));
      stop     = ($urandom_range(0, 3) != 0);
      clr_done = ($urandom_range(0, 3) == 0);
      if (stop) begin
        m_ovr    = m_rdy && !clr_done;
        m_rdy    = 1'b1;
        m_data   = byt;
        exp_ferr = 0;
      end else begin
        if (clr_done) begin
          m_rdy = 1'b0;
          m_ovr = 1'b0;
        end
        exp_ferr = 1;
      end
      send_bits(1'b1, $urandom_range(1, 4));
      f0 = ferr_total;
      send_frame(byt, stop, clr_done);
      check($sformatf("rnd%0d_data", n), 32'(data), 32'(m_data));
      check($sformatf("rnd%0d_rdy", n), 32'(rdy), 32'(m_rdy));
      check($sformatf("rnd%0d_ovr", n), 32'(overrun), 32'(m_ovr));
      check($sformatf("rnd%0d_ferr_cycles", n), 32'(ferr_total - f0), 32'(exp_ferr));
      if ($urandom_range(0, 2) == 0) begin
        pulse_clr();
        m_rdy = 1'b0;
        m_ovr = 1'b0;
        check($sformatf("rnd%0d_clr_rdy", n), 32'(rdy), 32'(m_rdy));
        check($sformatf("rnd%0d_clr_ovr", n), 32'(overrun), 32'(m_ovr));
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
